sm4_key_data_buf: RTL and testbench
===================================

Name: sm4_key_data_buf

Overview:
- Parametrised key/result store for the SM4 encryption accelerator on the RV32IM core.
- Holds a writable round-key word memory, pre-loaded with the team default key on reset, and streams BURST consecutive key words to the SM4 core on request.
- Captures one hash value and buffers encrypted blocks in a FIFO until the CPU drains them.
- Unlike the previous generation, contents persist when idle; they are cleared only by rst or clr.

Parameters:
- KEY_W, 32, key word width.
- KEY_DEPTH, 8, key words stored (>=1).
- BURST, 4, key words streamed per pull (1..KEY_DEPTH).
- DATA_W, 128, encrypted block width.
- DATA_DEPTH, 8, FIFO entries (power of two, >=2).
- HASH_W, 256, hash width.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  soft clear: flush FIFO, hash and overflow; abort pull. Key memory untouched.
- key_wr_en  in  1  key memory write strobe.
- key_wr_addr  in  clog2(KEY_DEPTH)  write address.
- key_wr_data  in  KEY_W  write data.
- key_lock  in  1  sets the sticky write lock.
- pull_start  in  1  starts a key burst.
- pull_base  in  clog2(KEY_DEPTH)  first key address of the burst.
- key_out  out  KEY_W  streamed key word.
- key_valid  out  1  key_out valid this cycle.
- pull_busy  out  1  burst in progress.
- save_hash  in  1  capture strobe for in_hash.
- in_hash  in  HASH_W  hash value.
- hash_out  out  HASH_W  stored hash.
- hash_valid  out  1  hash_out holds a captured value.
- save_data  in  1  FIFO push strobe (SM4 done flag).
- in_data  in  DATA_W  encrypted block.
- data_rd_en  in  1  FIFO pop request.
- data_out  out  DATA_W  popped block.
- data_valid  out  1  data_out valid (one-cycle pulse).
- data_full  out  1  FIFO full.
- data_empty  out  1  FIFO empty.
- data_count  out  clog2(DATA_DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky: push dropped while full.

Behaviour:
- Reset (rst=1 at edge):
  - key_mem[0..4] = 0x01234567, 0x29112000, 0x02982000, 0x02971959, 0x00972001; entries above 4 = 0; indices >= KEY_DEPTH are dropped.
  - key lock cleared; FSM to IDLE.
  - All outputs 0 except data_empty=1.
  - FIFO pointers and count 0.
  - rst mid-burst or mid-drain aborts immediately; next cycle matches the reset state.
- Priority: rst > clr > normal operation. Hash, FIFO and pull FSM operate concurrently and independently.
- Key write: key_mem[key_wr_addr] <= key_wr_data when key_wr_en=1, lock=0 and pull_busy=0; otherwise the write is silently ignored. key_lock=1 sets the lock, which stays set until rst.
- Pull FSM:
  - IDLE: on pull_start, load idx=pull_base, cnt=0, go to STREAM.
  - STREAM: key_out=key_mem[idx] (registered), key_valid=1, idx=(idx+1) mod KEY_DEPTH, cnt++. After BURST words go to IDLE.
  - pull_busy=1 in STREAM.
  - Latency: pull_start sampled at edge N -> first key_valid after edge N+1; BURST back-to-back valid cycles.
  - pull_start while busy is ignored.
  - key_valid=0 and key_out holds its last value in IDLE.
  - clr in STREAM returns to IDLE next edge.
- Hash: save_hash -> hash_out<=in_hash, hash_valid=1 next cycle. A repeat capture overwrites. clr or rst zeroes hash_out and hash_valid.
- FIFO:
  - Push when save_data=1 and not full.
  - Pop when data_rd_en=1 and not empty: data_out<=head, data_valid=1 the following cycle, otherwise data_valid=0 and data_out holds.
  - Pointers wrap modulo DATA_DEPTH.
  - Push while full without a pop: block dropped, overflow=1 (sticky until clr/rst).
  - Full with push and pop in the same cycle: both succeed, count unchanged, no overflow.
  - Empty with push and pop in the same cycle: push succeeds, pop ignored, data_valid=0.
  - Pop while empty: no effect.
  - data_full = (count==DATA_DEPTH); data_empty = (count==0); both registered-consistent with data_count.
  - clr empties the FIFO, clears overflow and data_valid.

Test Plan:
- Reset, then pull_start with pull_base=0 -> key_valid for 4 cycles starting the cycle after the edge following pull_start; key_out = 0x01234567, 0x29112000, 0x02982000, 0x02971959; pull_busy drops after the 4th word.
- Write key_mem[7]=0xDEADBEEF, then pull with pull_base=6 -> key_out 0, 0xDEADBEEF, 0x01234567, 0x29112000 (wrap). Assert key_lock, write 0x0 to addr 7, pull again -> 0xDEADBEEF unchanged.
- Push 8 blocks 0x1..0x8 -> data_full=1, data_count=8. Push a 9th -> dropped, overflow=1. Pop 8 -> data_out 0x1..0x8 in order, data_empty=1.
- FIFO full with simultaneous push 0xA5 and pop -> data_out=0x1, count stays 8, overflow stays 0. Empty with simultaneous push and pop -> count=1, data_valid=0.
- save_hash with in_hash = 256'h1234 -> hash_out=0x1234, hash_valid=1. Idle 10 cycles -> values retained. clr -> hash_valid=0, FIFO empty, overflow=0, key_mem intact.
- rst asserted during the 2nd cycle of a burst with 3 blocks queued -> next cycle key_valid=0, pull_busy=0, data_empty=1, key_mem back to defaults.

Source files
------------

// File: rtl/sm4_key_data_buf.sv
// Key/result store for the SM4 accelerator: writable round-key memory with burst
// streaming, a single hash capture register and an encrypted-block FIFO.
module sm4_key_data_buf #(
    parameter int KEY_W      = 32,
    parameter int KEY_DEPTH  = 8,
    parameter int BURST      = 4,
    parameter int DATA_W     = 128,
    parameter int DATA_DEPTH = 8,
    parameter int HASH_W     = 256,
    localparam int AW        = (KEY_DEPTH > 1) ? $clog2(KEY_DEPTH) : 1,
    localparam int DAW       = $clog2(DATA_DEPTH),
    localparam int CW        = DAW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              key_wr_en,
    input  logic [AW-1:0]     key_wr_addr,
    input  logic [KEY_W-1:0]  key_wr_data,
    input  logic              key_lock,
    input  logic              pull_start,
    input  logic [AW-1:0]     pull_base,
    output logic [KEY_W-1:0]  key_out,
    output logic              key_valid,
    output logic              pull_busy,
    input  logic              save_hash,
    input  logic [HASH_W-1:0] in_hash,
    output logic [HASH_W-1:0] hash_out,
    output logic              hash_valid,
    input  logic              save_data,
    input  logic [DATA_W-1:0] in_data,
    input  logic              data_rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              data_full,
    output logic              data_empty,
    output logic [CW-1:0]     data_count,
    output logic              overflow
);

    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [AW:0]    KEY_LIMIT = (AW+1)'(KEY_DEPTH);
    localparam logic [AW-1:0]  IDX_LAST  = AW'(KEY_DEPTH - 1);
    localparam logic [BW-1:0]  CNT_LAST  = BW'(BURST - 1);
    localparam logic [CW-1:0]  CNT_FULL  = CW'(DATA_DEPTH);

    typedef enum logic [0:0] {IDLE = 1'b0, STREAM = 1'b1} state_t;

    function automatic logic [KEY_W-1:0] key_default(input int idx);
        logic [KEY_W-1:0] val;
        case (idx)
            0:       val = KEY_W'(32'h0123_4567);
            1:       val = KEY_W'(32'h2911_2000);
            2:       val = KEY_W'(32'h0298_2000);
            3:       val = KEY_W'(32'h0297_1959);
            4:       val = KEY_W'(32'h0097_2001);
            default: val = '0;
        endcase
        return val;
    endfunction

    logic [KEY_W-1:0]  key_mem_q [KEY_DEPTH];
    logic [KEY_W-1:0]  key_mem_d [KEY_DEPTH];
    logic              lock_q, lock_d;
    state_t            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [BW-1:0]     cnt_q, cnt_d;
    logic [KEY_W-1:0]  key_out_q, key_out_d;
    logic              key_valid_q, key_valid_d;
    logic [HASH_W-1:0] hash_q, hash_d;
    logic              hash_valid_q, hash_valid_d;
    logic [DATA_W-1:0] fifo_mem_q [DATA_DEPTH];
    logic [DATA_W-1:0] fifo_mem_d [DATA_DEPTH];
    logic [DAW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, full_d, empty_q, empty_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              push_ok_s, pop_ok_s;

    // Key memory writes and sticky lock; writes are blocked while locked or streaming.
    always_comb begin
        key_mem_d = key_mem_q;
        lock_d    = lock_q | key_lock;
        if (key_wr_en && !lock_q && (state_q != STREAM) && !clr
            && ({1'b0, key_wr_addr} < KEY_LIMIT)) begin
            key_mem_d[key_wr_addr] = key_wr_data;
        end else begin
            key_mem_d = key_mem_q;
        end
    end

    // Pull FSM: next state and registered key stream outputs.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        key_out_d   = key_out_q;
        key_valid_d = 1'b0;
        if (clr) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pull_start) begin
                        idx_d   = ({1'b0, pull_base} < KEY_LIMIT) ? pull_base : '0;
                        cnt_d   = '0;
                        state_d = STREAM;
                    end else begin
                        state_d = IDLE;
                    end
                end
                STREAM: begin
                    key_out_d   = key_mem_q[idx_q];
                    key_valid_d = 1'b1;
                    idx_d       = (idx_q == IDX_LAST) ? '0 : idx_q + AW'(1);
                    cnt_d       = cnt_q + BW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                    end else begin
                        state_d = STREAM;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Hash capture register.
    always_comb begin
        hash_d       = hash_q;
        hash_valid_d = hash_valid_q;
        if (clr) begin
            hash_d       = '0;
            hash_valid_d = 1'b0;
        end else if (save_hash) begin
            hash_d       = in_hash;
            hash_valid_d = 1'b1;
        end else begin
            hash_d       = hash_q;
            hash_valid_d = hash_valid_q;
        end
    end

    // FIFO control: a pop frees the slot for a simultaneous push when full.
    always_comb begin
        pop_ok_s     = data_rd_en && !empty_q;
        push_ok_s    = save_data && (!full_q || pop_ok_s);
        fifo_mem_d   = fifo_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        ovf_d        = ovf_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push_ok_s) begin
                fifo_mem_d[wr_ptr_q] = in_data;
                wr_ptr_d             = wr_ptr_q + DAW'(1);
            end else begin
                ovf_d = ovf_q | save_data;
            end
            if (pop_ok_s) begin
                data_out_d   = fifo_mem_q[rd_ptr_q];
                data_valid_d = 1'b1;
                rd_ptr_d     = rd_ptr_q + DAW'(1);
            end else begin
                data_valid_d = 1'b0;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == '0);
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < KEY_DEPTH; i++) begin
                key_mem_q[i] <= key_default(i);
            end
            lock_q       <= 1'b0;
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            key_out_q    <= '0;
            key_valid_q  <= 1'b0;
            hash_q       <= '0;
            hash_valid_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            ovf_q        <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            key_mem_q    <= key_mem_d;
            lock_q       <= lock_d;
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            key_out_q    <= key_out_d;
            key_valid_q  <= key_valid_d;
            hash_q       <= hash_d;
            hash_valid_q <= hash_valid_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            ovf_q        <= ovf_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        fifo_mem_q <= fifo_mem_d;
    end

    assign key_out    = key_out_q;
    assign key_valid  = key_valid_q;
    assign pull_busy  = (state_q == STREAM);
    assign hash_out   = hash_q;
    assign hash_valid = hash_valid_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign data_full  = full_q;
    assign data_empty = empty_q;
    assign data_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_sm4_key_data_buf.sv
// Directed self-checking bench for sm4_key_data_buf with default parameters.
module tb_sm4_key_data_buf;

    logic         clk;
    logic         rst, clr;
    logic         key_wr_en;
    logic [2:0]   key_wr_addr;
    logic [31:0]  key_wr_data;
    logic         key_lock;
    logic         pull_start;
    logic [2:0]   pull_base;
    logic [31:0]  key_out;
    logic         key_valid, pull_busy;
    logic         save_hash;
    logic [255:0] in_hash, hash_out;
    logic         hash_valid;
    logic         save_data;
    logic [127:0] in_data, data_out;
    logic         data_rd_en, data_valid, data_full, data_empty;
    logic [3:0]   data_count;
    logic         overflow;

    int errors = 0;
    int checks = 0;

    sm4_key_data_buf dut (
        .clk(clk), .rst(rst), .clr(clr),
        .key_wr_en(key_wr_en), .key_wr_addr(key_wr_addr), .key_wr_data(key_wr_data),
        .key_lock(key_lock), .pull_start(pull_start), .pull_base(pull_base),
        .key_out(key_out), .key_valid(key_valid), .pull_busy(pull_busy),
        .save_hash(save_hash), .in_hash(in_hash), .hash_out(hash_out), .hash_valid(hash_valid),
        .save_data(save_data), .in_data(in_data), .data_rd_en(data_rd_en),
        .data_out(data_out), .data_valid(data_valid), .data_full(data_full),
        .data_empty(data_empty), .data_count(data_count), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start a burst and check the four streamed words and busy timing.
    task automatic pull_chk(input string tag, input logic [2:0] base,
                            input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] exp [4];
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        pull_start = 1'b1;
        pull_base  = base;
        step();
        pull_start = 1'b0;
        chk({tag, "_busy_start"}, 256'(pull_busy), 256'(1'b1));
        chk({tag, "_valid_lat"}, 256'(key_valid), 256'(1'b0));
        for (int i = 0; i < 4; i++) begin
            step();
            chk({tag, "_valid"}, 256'(key_valid), 256'(1'b1));
            chk({tag, "_word"}, 256'(key_out), 256'(exp[i]));
        end
        chk({tag, "_busy_end"}, 256'(pull_busy), 256'(1'b0));
        step();
        chk({tag, "_idle_valid"}, 256'(key_valid), 256'(1'b0));
        chk({tag, "_idle_hold"}, 256'(key_out), 256'(e3));
    endtask

    task automatic push(input logic [127:0] v);
        save_data = 1'b1;
        in_data   = v;
        step();
        save_data = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0;
        key_wr_en = 1'b0; key_wr_addr = 3'd0; key_wr_data = 32'h0; key_lock = 1'b0;
        pull_start = 1'b0; pull_base = 3'd0;
        save_hash = 1'b0; in_hash = 256'h0;
        save_data = 1'b0; in_data = 128'h0; data_rd_en = 1'b0;
        step();
        step();
        rst = 1'b0;

        chk("rst_key_valid", 256'(key_valid), 256'(1'b0));
        chk("rst_key_out", 256'(key_out), 256'(32'h0));
        chk("rst_busy", 256'(pull_busy), 256'(1'b0));
        chk("rst_hash_valid", 256'(hash_valid), 256'(1'b0));
        chk("rst_hash_out", hash_out, 256'h0);
        chk("rst_empty", 256'(data_empty), 256'(1'b1));
        chk("rst_full", 256'(data_full), 256'(1'b0));
        chk("rst_count", 256'(data_count), 256'(4'd0));
        chk("rst_overflow", 256'(overflow), 256'(1'b0));
        chk("rst_data_valid", 256'(data_valid), 256'(1'b0));

        pull_chk("pull0", 3'd0, 32'h01234567, 32'h29112000, 32'h02982000, 32'h02971959);

        key_wr_en = 1'b1; key_wr_addr = 3'd7; key_wr_data = 32'hDEADBEEF;
        step();
        key_wr_en = 1'b0;
        pull_chk("pull6", 3'd6, 32'h0, 32'hDEADBEEF, 32'h01234567, 32'h29112000);

        key_lock = 1'b1;
        step();
        key_lock = 1'b0;
        key_wr_en = 1'b1; key_wr_addr = 3'd7; key_wr_data = 32'h0;
        step();
        key_wr_en = 1'b0;
        pull_chk("pull_locked", 3'd6, 32'h0, 32'hDEADBEEF, 32'h01234567, 32'h29112000);

        // Fill, overflow, drain
        for (int i = 1; i <= 8; i++) push(128'(i));
        chk("fill_full", 256'(data_full), 256'(1'b1));
        chk("fill_count", 256'(data_count), 256'(4'd8));
        chk("fill_ovf", 256'(overflow), 256'(1'b0));
        push(128'h9);
        chk("ovf_set", 256'(overflow), 256'(1'b1));
        chk("ovf_count", 256'(data_count), 256'(4'd8));
        data_rd_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("drain_valid", 256'(data_valid), 256'(1'b1));
            chk("drain_data", 256'(data_out), 256'(i));
        end
        data_rd_en = 1'b0;
        chk("drain_empty", 256'(data_empty), 256'(1'b1));
        chk("drain_count", 256'(data_count), 256'(4'd0));
        step();
        chk("pop_idle_valid", 256'(data_valid), 256'(1'b0));
        chk("pop_idle_hold", 256'(data_out), 256'(128'h8));
        chk("ovf_sticky", 256'(overflow), 256'(1'b1));

        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_ovf", 256'(overflow), 256'(1'b0));

        // Full with simultaneous push/pop
        for (int i = 1; i <= 8; i++) push(128'(i));
        save_data = 1'b1; in_data = 128'hA5; data_rd_en = 1'b1;
        step();
        save_data = 1'b0; data_rd_en = 1'b0;
        chk("fullpp_data", 256'(data_out), 256'(128'h1));
        chk("fullpp_valid", 256'(data_valid), 256'(1'b1));
        chk("fullpp_count", 256'(data_count), 256'(4'd8));
        chk("fullpp_full", 256'(data_full), 256'(1'b1));
        chk("fullpp_ovf", 256'(overflow), 256'(1'b0));
        data_rd_en = 1'b1;
        for (int i = 2; i <= 9; i++) begin
            step();
            chk("fullpp_drain", 256'(data_out), (i == 9) ? 256'h0A5 : 256'(i));
        end
        data_rd_en = 1'b0;
        chk("fullpp_empty", 256'(data_empty), 256'(1'b1));

        // Empty with simultaneous push/pop
        save_data = 1'b1; in_data = 128'h77; data_rd_en = 1'b1;
        step();
        save_data = 1'b0; data_rd_en = 1'b0;
        chk("emptypp_count", 256'(data_count), 256'(4'd1));
        chk("emptypp_valid", 256'(data_valid), 256'(1'b0));
        data_rd_en = 1'b1;
        step();
        data_rd_en = 1'b0;
        chk("emptypp_pop", 256'(data_out), 256'(128'h77));

        // Hash capture and retention
        save_hash = 1'b1; in_hash = 256'h1234;
        step();
        save_hash = 1'b0;
        chk("hash_out", hash_out, 256'h1234);
        chk("hash_valid", 256'(hash_valid), 256'(1'b1));
        push(128'h11);
        push(128'h22);
        repeat (10) step();
        chk("hash_retain", hash_out, 256'h1234);
        chk("hash_valid_retain", 256'(hash_valid), 256'(1'b1));
        chk("fifo_retain", 256'(data_count), 256'(4'd2));

        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_hash_valid", 256'(hash_valid), 256'(1'b0));
        chk("clr_hash_out", hash_out, 256'h0);
        chk("clr_empty", 256'(data_empty), 256'(1'b1));
        chk("clr_count", 256'(data_count), 256'(4'd0));
        pull_chk("pull_after_clr", 3'd6, 32'h0, 32'hDEADBEEF, 32'h01234567, 32'h29112000);

        // Reset mid-burst with blocks queued
        push(128'h1); push(128'h2); push(128'h3);
        pull_start = 1'b1; pull_base = 3'd0;
        step();
        pull_start = 1'b0;
        step();
        chk("pre_rst_valid", 256'(key_valid), 256'(1'b1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_valid", 256'(key_valid), 256'(1'b0));
        chk("midrst_busy", 256'(pull_busy), 256'(1'b0));
        chk("midrst_key_out", 256'(key_out), 256'(32'h0));
        chk("midrst_empty", 256'(data_empty), 256'(1'b1));
        chk("midrst_count", 256'(data_count), 256'(4'd0));
        pull_chk("pull_defaults", 3'd6, 32'h0, 32'h0, 32'h01234567, 32'h29112000);

        // Lock cleared by reset
        key_wr_en = 1'b1; key_wr_addr = 3'd7; key_wr_data = 32'hCAFEF00D;
        step();
        key_wr_en = 1'b0;
        pull_chk("pull_unlocked", 3'd7, 32'hCAFEF00D, 32'h01234567, 32'h29112000, 32'h02982000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
